// File: rtl/imm_rotate_encoder_if.sv
// Valid/ready request and result bundle for imm_rotate_encoder.
// The master drives requests and accepts results; the slave is the encoder.
interface imm_rotate_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic        out_found;
  logic [11:0] out_shift_operand;
  logic        out_inverted;

  modport master (
    output in_valid, in_value, out_ready,
    input  in_ready, out_valid, out_found, out_shift_operand, out_inverted
  );

  modport slave (
    input  in_valid, in_value, out_ready,
    output in_ready, out_valid, out_found, out_shift_operand, out_inverted
  );
endinterface

// File: rtl/imm_rotate_encoder.sv
// Iterative search for a {rotate_imm, imm8} encoding of a 32-bit constant.
// Define IMM_ROT_ENC_INVERT_EN to also search ~value (MVN form) after a direct miss.
module imm_rotate_encoder #(
  parameter int ROT_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  imm_rotate_encoder_if.slave  bus
);

  localparam int         NUM_ROT  = 16;
  localparam logic [3:0] LAST_ROT = 4'(NUM_ROT - ROT_PER_CYCLE);
  localparam logic [3:0] ROT_STEP = 4'(ROT_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SEARCH     = 2'd1,
`ifdef IMM_ROT_ENC_INVERT_EN
    SEARCH_INV = 2'd2,
`endif
    DONE       = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  rot_q, rot_d;
  logic        found_q, found_d;
  logic [11:0] op_q, op_d;
`ifdef IMM_ROT_ENC_INVERT_EN
  logic        inv_q, inv_d;
`endif
  logic [31:0] value_q;
  logic        load;

  logic [31:0] src;
  logic        hit;
  logic [3:0]  hit_rot;
  logic [7:0]  hit_imm;

  // Rotating left by 2r undoes the decoder's rotate-right by 2r.
  function automatic logic [31:0] rotl_even(input logic [31:0] v, input logic [3:0] r);
    return 32'(({v, v} << {r, 1'b0}) >> 32);
  endfunction

  // Candidate check: lowest rotation in this cycle's window wins.
  always_comb begin
    logic [31:0] cand;
    logic [3:0]  rr;
    cand    = '0;
    rr      = '0;
    src     = value_q;
`ifdef IMM_ROT_ENC_INVERT_EN
    if (state_q == SEARCH_INV) src = ~value_q;
`endif
    hit     = 1'b0;
    hit_rot = '0;
    hit_imm = '0;
    for (int k = 0; k < ROT_PER_CYCLE; k++) begin
      rr   = rot_q + 4'(k);
      cand = rotl_even(src, rr);
      if (!hit && (cand[31:8] == 24'd0)) begin
        hit     = 1'b1;
        hit_rot = rr;
        hit_imm = cand[7:0];
      end
    end
  end

  // Next-state and result update
  always_comb begin
    state_d = state_q;
    rot_d   = rot_q;
    found_d = found_q;
    op_d    = op_q;
`ifdef IMM_ROT_ENC_INVERT_EN
    inv_d   = inv_q;
`endif
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          load    = 1'b1;
          rot_d   = '0;
          found_d = 1'b0;
          op_d    = '0;
`ifdef IMM_ROT_ENC_INVERT_EN
          inv_d   = 1'b0;
`endif
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (hit) begin
          found_d = 1'b1;
          op_d    = {hit_rot, hit_imm};
          state_d = DONE;
        end else if (rot_q == LAST_ROT) begin
          rot_d   = '0;
          found_d = 1'b0;
          op_d    = '0;
`ifdef IMM_ROT_ENC_INVERT_EN
          state_d = SEARCH_INV;
`else
          state_d = DONE;
`endif
        end else begin
          rot_d = rot_q + ROT_STEP;
        end
      end
`ifdef IMM_ROT_ENC_INVERT_EN
      SEARCH_INV: begin
        if (hit) begin
          found_d = 1'b1;
          op_d    = {hit_rot, hit_imm};
          inv_d   = 1'b1;
          state_d = DONE;
        end else if (rot_q == LAST_ROT) begin
          rot_d   = '0;
          found_d = 1'b0;
          op_d    = '0;
          inv_d   = 1'b0;
          state_d = DONE;
        end else begin
          rot_d = rot_q + ROT_STEP;
        end
      end
`endif
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rot_q   <= '0;
      found_q <= 1'b0;
      op_q    <= '0;
`ifdef IMM_ROT_ENC_INVERT_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rot_q   <= rot_d;
      found_q <= found_d;
      op_q    <= op_d;
`ifdef IMM_ROT_ENC_INVERT_EN
      inv_q   <= inv_d;
`endif
    end
  end

  // The latched constant is pure data and is only meaningful after a load.
  always_ff @(posedge clk) begin
    if (load) value_q <= bus.in_value;
  end

  assign bus.in_ready          = (state_q == IDLE);
  assign bus.out_valid         = (state_q == DONE);
  assign bus.out_found         = found_q;
  assign bus.out_shift_operand = op_q;
`ifdef IMM_ROT_ENC_INVERT_EN
  assign bus.out_inverted      = inv_q;
`else
  assign bus.out_inverted      = 1'b0;
`endif

endmodule

// File: tb/tb_imm_rotate_encoder.sv
// Drives a 1-rotation/cycle and a 4-rotation/cycle encoder in lockstep and
// compares both against a decode-enumeration reference model.
module tb_imm_rotate_encoder;

`ifdef IMM_ROT_ENC_INVERT_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic        last_found1, last_found4, last_inv1, last_inv4;
  logic [11:0] last_op1, last_op4;

  always #5 clk = ~clk;

  imm_rotate_encoder_if bus1 ();
  imm_rotate_encoder_if bus4 ();

  imm_rotate_encoder #(.ROT_PER_CYCLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  imm_rotate_encoder #(.ROT_PER_CYCLE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
    return (x >> s) | (x << (32 - s));
  endfunction

  // Reference: find the lowest rotation r and imm8 whose decode equals the target.
  function automatic void ref_model(input logic [31:0] v, output logic f, output logic [11:0] op,
                                    output logic inv, output int p_hit, output int r_hit);
    logic [31:0] tgt;
    f = 1'b0; op = '0; inv = 1'b0; p_hit = 0; r_hit = 0;
    for (int p = 0; p < NPASS && !f; p++) begin
      tgt = (p == 0) ? v : ~v;
      for (int r = 0; r < 16 && !f; r++)
        for (int i = 0; i < 256 && !f; i++)
          if (ror32(32'(i), 2 * r) == tgt) begin
            f = 1'b1; op = {4'(r), 8'(i)}; inv = (p == 1); p_hit = p; r_hit = r;
          end
    end
  endfunction

  function automatic int exp_lat(input int rpc, input logic f, input int p, input int r);
    return f ? (p * (16 / rpc) + r / rpc + 1) : (NPASS * (16 / rpc));
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_rdy1"},   32'(bus1.in_ready), 32'd1);
    check_eq({tag, "_vld1"},   32'(bus1.out_valid), 32'd0);
    check_eq({tag, "_found1"}, 32'(bus1.out_found), 32'd0);
    check_eq({tag, "_op1"},    32'(bus1.out_shift_operand), 32'd0);
    check_eq({tag, "_inv1"},   32'(bus1.out_inverted), 32'd0);
    check_eq({tag, "_rdy4"},   32'(bus4.in_ready), 32'd1);
    check_eq({tag, "_vld4"},   32'(bus4.out_valid), 32'd0);
    check_eq({tag, "_found4"}, 32'(bus4.out_found), 32'd0);
    check_eq({tag, "_op4"},    32'(bus4.out_shift_operand), 32'd0);
    check_eq({tag, "_inv4"},   32'(bus4.out_inverted), 32'd0);
  endtask

  task automatic accept(input logic [31:0] v, input string tag);
    check_eq({tag, "_rdy1"}, 32'(bus1.in_ready), 32'd1);
    check_eq({tag, "_rdy4"}, 32'(bus4.in_ready), 32'd1);
    bus1.in_valid = 1'b1; bus1.in_value = v;
    bus4.in_valid = 1'b1; bus4.in_value = v;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0; bus4.in_valid = 1'b0;
    check_eq({tag, "_busy1"}, 32'(bus1.in_ready), 32'd0);
    check_eq({tag, "_busy4"}, 32'(bus4.in_ready), 32'd0);
  endtask

  // Called just after the accept edge; checks latency and result of both DUTs.
  task automatic wait_result(input logic [31:0] v, input string tag);
    logic        ef, einv;
    logic [11:0] eop;
    int          ep, er, lat1, lat4;
    ref_model(v, ef, eop, einv, ep, er);
    lat1 = -1; lat4 = -1;
    for (int c = 1; c <= 80; c++) begin
      if (lat1 >= 0 && lat4 >= 0) break;
      @(posedge clk); #1;
      if (lat1 < 0 && bus1.out_valid) begin
        lat1 = c;
        last_found1 = bus1.out_found; last_op1 = bus1.out_shift_operand; last_inv1 = bus1.out_inverted;
        check_eq({tag, "_found1"}, 32'(bus1.out_found), 32'(ef));
        check_eq({tag, "_op1"},    32'(bus1.out_shift_operand), 32'(eop));
        check_eq({tag, "_inv1"},   32'(bus1.out_inverted), 32'(einv));
      end
      if (lat4 < 0 && bus4.out_valid) begin
        lat4 = c;
        last_found4 = bus4.out_found; last_op4 = bus4.out_shift_operand; last_inv4 = bus4.out_inverted;
        check_eq({tag, "_found4"}, 32'(bus4.out_found), 32'(ef));
        check_eq({tag, "_op4"},    32'(bus4.out_shift_operand), 32'(eop));
        check_eq({tag, "_inv4"},   32'(bus4.out_inverted), 32'(einv));
      end
    end
    check_eq({tag, "_lat1"}, lat1, exp_lat(1, ef, ep, er));
    check_eq({tag, "_lat4"}, lat4, exp_lat(4, ef, ep, er));
    @(posedge clk); #1;
  endtask

  task automatic run_txn(input logic [31:0] v, input string tag);
    accept(v, tag);
    wait_result(v, tag);
  endtask

  task automatic check_last(input string tag, input logic f, input logic [11:0] op, input logic inv);
    check_eq({tag, "_kfound1"}, 32'(last_found1), 32'(f));
    check_eq({tag, "_kop1"},    32'(last_op1), 32'(op));
    check_eq({tag, "_kinv1"},   32'(last_inv1), 32'(inv));
    check_eq({tag, "_kop4"},    32'(last_op4), 32'(op));
  endtask

  task automatic backpressure(input logic [31:0] v1, input logic [31:0] v2);
    logic        f1, f4, i1, i4;
    logic [11:0] o1, o4;
    bus1.out_ready = 1'b0; bus4.out_ready = 1'b0;
    run_txn(v1, "bp_first");
    f1 = bus1.out_found; o1 = bus1.out_shift_operand; i1 = bus1.out_inverted;
    f4 = bus4.out_found; o4 = bus4.out_shift_operand; i4 = bus4.out_inverted;
    bus1.in_valid = 1'b1; bus1.in_value = v2;
    bus4.in_valid = 1'b1; bus4.in_value = v2;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check_eq("bp_hold_vld1", 32'(bus1.out_valid), 32'd1);
      check_eq("bp_hold_rdy1", 32'(bus1.in_ready), 32'd0);
      check_eq("bp_hold_out1", {19'd0, bus1.out_found, bus1.out_inverted, bus1.out_shift_operand},
               {19'd0, f1, i1, o1});
      check_eq("bp_hold_vld4", 32'(bus4.out_valid), 32'd1);
      check_eq("bp_hold_rdy4", 32'(bus4.in_ready), 32'd0);
      check_eq("bp_hold_out4", {19'd0, bus4.out_found, bus4.out_inverted, bus4.out_shift_operand},
               {19'd0, f4, i4, o4});
    end
    bus1.out_ready = 1'b1; bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_release_vld1", 32'(bus1.out_valid), 32'd0);
    check_eq("bp_release_rdy1", 32'(bus1.in_ready), 32'd1);
    check_eq("bp_release_rdy4", 32'(bus4.in_ready), 32'd1);
    @(posedge clk); #1;
    bus1.in_valid = 1'b0; bus4.in_valid = 1'b0;
    check_eq("bp_pending_taken1", 32'(bus1.in_ready), 32'd0);
    check_eq("bp_pending_taken4", 32'(bus4.in_ready), 32'd0);
    wait_result(v2, "bp_second");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    bus1.in_valid = 1'b0; bus1.in_value = '0; bus1.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.in_value = '0; bus4.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn(32'h0000_00FF, "d_ff");
    check_last("d_ff", 1'b1, 12'h0FF, 1'b0);
    run_txn(32'hFF00_0000, "d_ff000000");
    check_last("d_ff000000", 1'b1, 12'h4FF, 1'b0);
    run_txn(32'h0000_0104, "d_104");
    check_last("d_104", 1'b1, 12'hF41, 1'b0);
    run_txn(32'h0000_0102, "d_102");
    check_last("d_102", 1'b0, 12'h000, 1'b0);
    run_txn(32'h0000_0000, "d_zero");
    check_last("d_zero", 1'b1, 12'h000, 1'b0);
    run_txn(32'hFFFF_FF00, "d_mvn");
`ifdef IMM_ROT_ENC_INVERT_EN
    check_last("d_mvn", 1'b1, 12'h0FF, 1'b1);
`else
    check_last("d_mvn", 1'b0, 12'h000, 1'b0);
`endif

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0:       v = ror32(32'($urandom_range(0, 255)), 2 * $urandom_range(0, 15));
        1:       v = ~ror32(32'($urandom_range(0, 255)), 2 * $urandom_range(0, 15));
        2:       v = $urandom;
        default: v = 32'($urandom_range(0, 1023));
      endcase
      run_txn(v, "rnd");
    end

    backpressure(32'h0003_FC00, 32'h8000_003F);

    accept(32'h0000_0102, "rst_mid");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_async");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn(32'h0000_03FC, "post_rst");
    check_last("post_rst", 1'b1, 12'hFFF, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
